// File: rtl/tlb_array.sv
// tlb_array: TLB entry storage with a combinational read port, a
// registered write port and a three-state probe engine (IDLE/SEARCH/DONE).
// Optional feature macro: TLB_SEARCH_PORT_EN adds a combinational
// translation port (s_*). With the macro undefined those ports and their
// logic are absent.

// Per-entry match: VPN2 must match, and either the entry is global or
// the ASIDs agree. Valid bits take no part in matching.
module tlb_match (
    input  logic [18:0] entry_vpn2,
    input  logic [7:0]  entry_asid,
    input  logic        entry_g,
    input  logic [18:0] key_vpn2,
    input  logic [7:0]  key_asid,
    output logic        hit
);
    assign hit = (entry_vpn2 == key_vpn2) && (entry_g || (entry_asid == key_asid));
endmodule

module tlb_array #(
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        reset,
    // write port
    input  logic        we,
    input  logic [3:0]  w_index,
    input  logic [18:0] w_vpn2,
    input  logic [7:0]  w_asid,
    input  logic        w_g,
    input  logic [19:0] w_pfn0,
    input  logic [2:0]  w_c0,
    input  logic        w_d0,
    input  logic        w_v0,
    input  logic [19:0] w_pfn1,
    input  logic [2:0]  w_c1,
    input  logic        w_d1,
    input  logic        w_v1,
    // read port
    input  logic [3:0]  r_index,
    output logic [18:0] r_vpn2,
    output logic [7:0]  r_asid,
    output logic        r_g,
    output logic [19:0] r_pfn0,
    output logic [2:0]  r_c0,
    output logic        r_d0,
    output logic        r_v0,
    output logic [19:0] r_pfn1,
    output logic [2:0]  r_c1,
    output logic        r_d1,
    output logic        r_v1,
`ifdef TLB_SEARCH_PORT_EN
    // translation port
    input  logic [18:0] s_vpn2,
    input  logic        s_odd,
    input  logic [7:0]  s_asid,
    output logic        s_found,
    output logic [3:0]  s_index,
    output logic [19:0] s_pfn,
    output logic [2:0]  s_c,
    output logic        s_d,
    output logic        s_v,
`endif
    // probe port
    input  logic        TLBP,
    input  logic [31:0] EntryHi,
    output logic [5:0]  TLBP_result
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } probe_state_t;

    tlb_entry_t   entries [TLBNUM];
    probe_state_t state;
    logic [18:0]  key_vpn2;
    logic [7:0]   key_asid;

    logic [TLBNUM-1:0] probe_hit;
    logic              probe_found;
    logic [3:0]        probe_idx;

    // EntryHi[12:8] carries no key information
    logic unused_entryhi;
    assign unused_entryhi = ^EntryHi[12:8];

    // Lowest set bit wins when several entries match
    function automatic logic [3:0] lowest_hit(input logic [TLBNUM-1:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Entry storage: reset clears every field, otherwise one write per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
        end else if (we && (32'(w_index) < TLBNUM)) begin
            entries[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                                  pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                                  pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
        end
    end

    // Read port is a plain view of the stored entry (old data during a write)
    assign r_vpn2 = entries[r_index].vpn2;
    assign r_asid = entries[r_index].asid;
    assign r_g    = entries[r_index].g;
    assign r_pfn0 = entries[r_index].pfn0;
    assign r_c0   = entries[r_index].c0;
    assign r_d0   = entries[r_index].d0;
    assign r_v0   = entries[r_index].v0;
    assign r_pfn1 = entries[r_index].pfn1;
    assign r_c1   = entries[r_index].c1;
    assign r_d1   = entries[r_index].d1;
    assign r_v1   = entries[r_index].v1;

    // Parallel comparators against the latched probe key
    genvar gi;
    generate
        for (gi = 0; gi < TLBNUM; gi++) begin : g_probe
            tlb_match u_match (
                .entry_vpn2 (entries[gi].vpn2),
                .entry_asid (entries[gi].asid),
                .entry_g    (entries[gi].g),
                .key_vpn2   (key_vpn2),
                .key_asid   (key_asid),
                .hit        (probe_hit[gi])
            );
        end
    endgenerate

    // Probe hit reduction; index is zero when nothing matches
    always_comb begin
        probe_found = |probe_hit;
        probe_idx   = lowest_hit(probe_hit);
    end

    // Probe FSM: latch key, compare for one cycle, hold result while TLBP stays high.
    // The result is captured at the SEARCH->DONE edge, so later writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            key_vpn2    <= '0;
            key_asid    <= '0;
            TLBP_result <= 6'h00;
        end else begin
            case (state)
                IDLE: begin
                    TLBP_result <= 6'h00;
                    if (TLBP) begin
                        key_vpn2 <= EntryHi[31:13];
                        key_asid <= EntryHi[7:0];
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    TLBP_result <= {1'b1, probe_found, probe_idx};
                    state       <= DONE;
                end
                DONE: begin
                    if (!TLBP) begin
                        TLBP_result <= 6'h00;
                        state       <= IDLE;
                    end
                end
                default: begin
                    TLBP_result <= 6'h00;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef TLB_SEARCH_PORT_EN
    logic [TLBNUM-1:0] s_hit;
    tlb_entry_t        s_sel;

    generate
        for (gi = 0; gi < TLBNUM; gi++) begin : g_search
            tlb_match u_match (
                .entry_vpn2 (entries[gi].vpn2),
                .entry_asid (entries[gi].asid),
                .entry_g    (entries[gi].g),
                .key_vpn2   (s_vpn2),
                .key_asid   (s_asid),
                .hit        (s_hit[gi])
            );
        end
    endgenerate

    // Translation: pick even/odd page of the lowest matching entry, zeros on miss
    always_comb begin
        s_found = |s_hit;
        s_index = lowest_hit(s_hit);
        s_sel   = entries[s_index];
        s_pfn   = '0;
        s_c     = '0;
        s_d     = 1'b0;
        s_v     = 1'b0;
        if (s_found) begin
            s_pfn = s_odd ? s_sel.pfn1 : s_sel.pfn0;
            s_c   = s_odd ? s_sel.c1   : s_sel.c0;
            s_d   = s_odd ? s_sel.d1   : s_sel.d0;
            s_v   = s_odd ? s_sel.v1   : s_sel.v0;
        end
    end
`endif

endmodule

// File: tb/tb_tlb_array.sv
// Bench for tlb_array: table-driven write/read and probe vectors, a queue
// scoreboard for probe results, and hand sequences for the multi-cycle cases
// (write during SEARCH/DONE, reset in DONE).
module tb_tlb_array;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } ent_t;

    typedef struct {
        logic [3:0] idx;
        ent_t       e;
    } wvec_t;

    typedef struct {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [5:0]  exp;
    } pvec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic        w_g;
    logic [19:0] w_pfn0;
    logic [2:0]  w_c0;
    logic        w_d0;
    logic        w_v0;
    logic [19:0] w_pfn1;
    logic [2:0]  w_c1;
    logic        w_d1;
    logic        w_v1;
    logic [3:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0;
    logic [2:0]  r_c0;
    logic        r_d0;
    logic        r_v0;
    logic [19:0] r_pfn1;
    logic [2:0]  r_c1;
    logic        r_d1;
    logic        r_v1;
    logic        TLBP;
    logic [31:0] EntryHi;
    logic [5:0]  TLBP_result;
`ifdef TLB_SEARCH_PORT_EN
    logic [18:0] s_vpn2;
    logic        s_odd;
    logic [7:0]  s_asid;
    logic        s_found;
    logic [3:0]  s_index;
    logic [19:0] s_pfn;
    logic [2:0]  s_c;
    logic        s_d;
    logic        s_v;
`endif

    int checks   = 0;
    int failures = 0;
    logic [5:0] sb [$];
    logic prev_v = 1'b0;

    tlb_array #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
`ifdef TLB_SEARCH_PORT_EN
        .s_vpn2(s_vpn2), .s_odd(s_odd), .s_asid(s_asid), .s_found(s_found),
        .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
`endif
        .TLBP(TLBP), .EntryHi(EntryHi), .TLBP_result(TLBP_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [77:0] rd_vec();
        return {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
    endfunction

    task automatic drive_w(input logic [3:0] idx, input ent_t e);
        w_index = idx;
        w_vpn2 = e.vpn2; w_asid = e.asid; w_g = e.g;
        w_pfn0 = e.pfn0; w_c0 = e.c0; w_d0 = e.d0; w_v0 = e.v0;
        w_pfn1 = e.pfn1; w_c1 = e.c1; w_d1 = e.d1; w_v1 = e.v1;
    endtask

    task automatic write(input logic [3:0] idx, input ent_t e);
        drive_w(idx, e);
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    function automatic ent_t mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g);
        ent_t e;
        e = '0;
        e.vpn2 = vpn2; e.asid = asid; e.g = g;
        return e;
    endfunction

    // Full probe handshake with latency and hold checks; value checked by the scoreboard
    task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid, input logic [5:0] exp);
        int n;
        sb.push_back(exp);
        EntryHi = {vpn2, 5'b0, asid};
        TLBP = 1'b1;
        check("probe_idle_zero", TLBP_result, 6'h00);
        tick();
        check("probe_search_zero", TLBP_result, 6'h00);
        n = 0;
        while (!TLBP_result[5] && n < 4) begin
            tick();
            n++;
        end
        check("probe_latency", n, 1);
        tick();
        check("probe_hold", TLBP_result, exp);
        TLBP = 1'b0;
        tick();
        check("probe_release", TLBP_result, 6'h00);
    endtask

    // Scoreboard: every rising valid pops one expected result
    always @(negedge clk) begin
        if (TLBP_result[5] && !prev_v) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h expected=none", TLBP_result);
            end else begin
                check("sb_result", TLBP_result, sb.pop_front());
            end
        end
        prev_v = TLBP_result[5];
    end

    wvec_t wtab [2];
    pvec_t ptab [8];
    ent_t  e5;

    initial begin
        wtab[0] = '{4'd15, '{19'h7FFFF, 8'hFF, 1'b0, 20'hFFFFF, 3'd7, 1'b1, 1'b1, 20'h00001, 3'd5, 1'b0, 1'b1}};
        wtab[1] = '{4'd14, '{19'h2AAAA, 8'h55, 1'b1, 20'h12345, 3'd2, 1'b0, 1'b0, 20'hFEDCB, 3'd3, 1'b1, 1'b0}};
        ptab[0] = '{19'h00000, 8'h00, 6'h30};
        ptab[1] = '{19'h00000, 8'h11, 6'h20};
        ptab[2] = '{19'h00123, 8'hFF, 6'h33};
        ptab[3] = '{19'h12345, 8'h00, 6'h35};
        ptab[4] = '{19'h00777, 8'h12, 6'h39};
        ptab[5] = '{19'h7FFFF, 8'hFF, 6'h3F};
        ptab[6] = '{19'h7FFFF, 8'hFE, 6'h20};
        ptab[7] = '{19'h2AAAA, 8'h99, 6'h3E};

        reset = 1'b1; we = 1'b0; TLBP = 1'b0; EntryHi = '0; r_index = '0;
        drive_w(4'd0, '0);
`ifdef TLB_SEARCH_PORT_EN
        s_vpn2 = '0; s_odd = 1'b0; s_asid = '0;
`endif
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset state
        check("reset_result", TLBP_result, 6'h00);
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            #1;
            check($sformatf("reset_entry%0d", i), rd_vec(), 78'h0);
        end

        // write table, read back every field
        foreach (wtab[i]) write(wtab[i].idx, wtab[i].e);
        foreach (wtab[i]) begin
            r_index = wtab[i].idx;
            #1;
            check($sformatf("readback_%0d", wtab[i].idx), rd_vec(), wtab[i].e);
        end

        // write entry 5; same-cycle read sees old contents
        e5 = mk(19'h12345, 8'h3A, 1'b0);
        e5.pfn0 = 20'hABCDE; e5.v0 = 1'b1;
        drive_w(4'd5, e5);
        we = 1'b1;
        r_index = 4'd5;
        #1;
        check("rw_same_cycle_old", rd_vec(), 78'h0);
        tick();
        we = 1'b0;
        check("rw_next_cycle_new", rd_vec(), e5);

`ifdef TLB_SEARCH_PORT_EN
        s_vpn2 = 19'h12345; s_asid = 8'h3A; s_odd = 1'b0;
        #1;
        check("search_even", {s_found, s_index, s_pfn, s_c, s_d, s_v}, {1'b1, 4'd5, 20'hABCDE, 3'd0, 1'b0, 1'b1});
        s_odd = 1'b1;
        #1;
        check("search_odd", {s_found, s_index, s_pfn, s_c, s_d, s_v}, {1'b1, 4'd5, 20'h0, 3'd0, 1'b0, 1'b0});
        s_asid = 8'h3B;
        #1;
        check("search_miss", {s_found, s_index, s_pfn, s_c, s_d, s_v}, 30'h0);
`endif

        // basic probe, ASID mismatch, then global entry
        probe(19'h12345, 8'h3A, 6'h35);
        probe(19'h12345, 8'h3B, 6'h20);
        e5.g = 1'b1;
        write(4'd5, e5);
        probe(19'h12345, 8'h3B, 6'h35);

        // two matching globals; write during SEARCH and during DONE
        write(4'd3, mk(19'h00777, 8'h01, 1'b1));
        write(4'd9, mk(19'h00777, 8'h02, 1'b1));
        sb.push_back(6'h33);
        EntryHi = {19'h00777, 5'b0, 8'h00};
        TLBP = 1'b1;
        tick();
        drive_w(4'd3, mk(19'h00123, 8'h01, 1'b1));
        we = 1'b1;
        tick();
        we = 1'b0;
        check("write_in_search", TLBP_result, 6'h33);
        drive_w(4'd1, mk(19'h00777, 8'h00, 1'b1));
        we = 1'b1;
        tick();
        we = 1'b0;
        check("write_in_done", TLBP_result, 6'h33);
        TLBP = 1'b0;
        tick();
        check("multi_release", TLBP_result, 6'h00);
        write(4'd1, '0);
        probe(19'h00777, 8'h00, 6'h39);

        // probe table
        foreach (ptab[i]) probe(ptab[i].vpn2, ptab[i].asid, ptab[i].exp);

        // reset while in DONE, with we and TLBP both high
        sb.push_back(6'h35);
        EntryHi = {19'h12345, 5'b0, 8'h3A};
        TLBP = 1'b1;
        tick(); tick();
        check("pre_reset_done", TLBP_result, 6'h35);
        reset = 1'b1;
        drive_w(4'd7, mk(19'h11111, 8'h22, 1'b1));
        we = 1'b1;
        tick();
        reset = 1'b0;
        we = 1'b0;
        check("reset_in_done_result", TLBP_result, 6'h00);
        r_index = 4'd5;
        #1;
        check("reset_entry5_v0", r_v0, 1'b0);
        check("reset_entry5_all", rd_vec(), 78'h0);
        r_index = 4'd7;
        #1;
        check("reset_blocks_write", rd_vec(), 78'h0);
        // TLBP still high: restart from IDLE against cleared table
        sb.push_back(6'h20);
        tick();
        check("post_reset_search", TLBP_result, 6'h00);
        tick();
        check("post_reset_done", TLBP_result, 6'h20);
        TLBP = 1'b0;
        tick();
        check("post_reset_release", TLBP_result, 6'h00);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
